// File: rtl/cache_req_queue_if.sv
// Core/cache handshake bundle for cache_req_queue: request intake, cache issue
// channel and completion response. The queue is the slave; the environment is the master.
interface cache_req_queue_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [31:0] in_data;
   logic [1:0]  in_type;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic [1:0]  req_type;
   logic        req_do;
   logic        req_done;
   logic [31:0] cache_data;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_type;

   modport slave (
      input  in_valid, in_addr, in_data, in_type, req_done, cache_data,
      output in_ready, req_addr, req_data, req_type, req_do, rsp_valid, rsp_data, rsp_type
   );

   modport master (
      output in_valid, in_addr, in_data, in_type, req_done, cache_data,
      input  in_ready, req_addr, req_data, req_type, req_do, rsp_valid, rsp_data, rsp_type
   );
endinterface

// File: rtl/cache_req_queue.sv
// Circular request FIFO in front of a single-outstanding cache port: entries are
// issued one at a time from the head and completed strictly in enqueue order.
module cache_req_queue #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   cache_req_queue_if.slave       bus,
   output logic [$clog2(DEPTH):0] count,
   output logic                   err_illegal
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   localparam logic [1:0] T_READ    = 2'b00;
   localparam logic [1:0] T_ILLEGAL = 2'b11;

   logic [31:0]      addr_mem [DEPTH];
   logic [31:0]      data_mem [DEPTH];
   logic [1:0]       type_mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [1:0]       state;
   logic             accept;
   logic             push;
   logic             pop;
   logic             busy;
   logic             vld_p1;
   logic [31:0]      rsp_data_p1;
   logic [1:0]       rsp_type_p1;

   // in_ready looks only at the registered count, so a same-cycle pop never frees a slot early.
   assign bus.in_ready = (count < FULL);
   assign accept       = bus.in_valid && bus.in_ready;
   assign push         = accept && (bus.in_type != T_ILLEGAL);
   assign pop          = (state == ST_WAIT) && bus.req_done;

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[tail] <= bus.in_addr;
         data_mem[tail] <= bus.in_data;
         type_mem[tail] <= bus.in_type;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         state       <= ST_IDLE;
         err_illegal <= 1'b0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (accept && (bus.in_type == T_ILLEGAL)) err_illegal <= 1'b1;
         case (state)
            ST_IDLE:  if (count != '0) state <= ST_ISSUE;
            ST_ISSUE: state <= ST_WAIT;
            ST_WAIT:  if (bus.req_done) state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   // Response stage: completion captured on the req_done edge, presented the cycle after.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p1      <= 1'b0;
         rsp_data_p1 <= '0;
         rsp_type_p1 <= '0;
      end else begin
         vld_p1 <= pop;
         if (pop) begin
            rsp_type_p1 <= type_mem[head];
            rsp_data_p1 <= (type_mem[head] == T_READ) ? bus.cache_data : '0;
         end
      end
   end

   // Head stays put during ISSUE/WAIT and a push never lands on it, so the request is stable.
   assign busy          = (state != ST_IDLE);
   assign bus.req_do    = (state == ST_ISSUE);
   assign bus.req_addr  = busy ? addr_mem[head] : '0;
   assign bus.req_data  = busy ? data_mem[head] : '0;
   assign bus.req_type  = busy ? type_mem[head] : '0;
   assign bus.rsp_valid = vld_p1;
   assign bus.rsp_data  = rsp_data_p1;
   assign bus.rsp_type  = rsp_type_p1;
endmodule

// File: tb/tb_cache_req_queue.sv
// Bench for cache_req_queue: transaction-level queue model checked every cycle,
// a randomised cache responder, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_cache_req_queue;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  typ;
   } ent_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [CW-1:0] count;
   logic          err_illegal;

   cache_req_queue_if bus();

   cache_req_queue #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .count       (count),
      .err_illegal (err_illegal)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the queue is a list of entries (head is the one in flight).
   ent_t        mq[$];
   bit          m_issue = 1'b0;
   bit          m_wait  = 1'b0;
   bit          m_rspv  = 1'b0;
   bit          m_err   = 1'b0;
   logic [31:0] m_rspd  = '0;
   logic [1:0]  m_rspt  = '0;

   logic [31:0] issue_log[$];
   int          do_cnt  = 0;
   int          rsp_cnt = 0;
   int          cyc     = 0;
   int          last_do = -100;

   task automatic model_step();
      bit   quiet;
      int   occ;
      ent_t e;
      occ   = mq.size();
      quiet = !m_issue && !m_wait;
      m_rspv = 1'b0;
      if (m_wait && bus.req_done) begin
         m_rspv = 1'b1;
         m_rspt = mq[0].typ;
         m_rspd = (mq[0].typ == 2'b00) ? bus.cache_data : 32'h0;
         mq.delete(0);
         m_wait = 1'b0;
      end else if (m_issue) begin
         m_wait = 1'b1;
      end
      m_issue = quiet && (occ > 0);
      if (bus.in_valid && (occ < DEPTH)) begin
         if (bus.in_type == 2'b11) m_err = 1'b1;
         else begin
            e.addr = bus.in_addr;
            e.data = bus.in_data;
            e.typ  = bus.in_type;
            mq.push_back(e);
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (!reset) begin
            mq.delete();
            m_issue = 1'b0; m_wait = 1'b0; m_rspv = 1'b0; m_err = 1'b0;
            m_rspd = '0; m_rspt = '0;
            last_do = -100;
         end else begin
            model_step();
         end
         #1;
         check("count", 32'(count), 32'(mq.size()));
         check("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
         check("req_do", 32'(bus.req_do), 32'(m_issue));
         if (m_issue || m_wait) begin
            check("req_addr", bus.req_addr, mq[0].addr);
            check("req_data", bus.req_data, mq[0].data);
            check("req_type", 32'(bus.req_type), 32'(mq[0].typ));
         end else begin
            check("req_addr_idle", bus.req_addr, 32'h0);
            check("req_data_idle", bus.req_data, 32'h0);
            check("req_type_idle", 32'(bus.req_type), 32'h0);
         end
         check("rsp_valid", 32'(bus.rsp_valid), 32'(m_rspv));
         if (m_rspv || !reset) begin
            check("rsp_data", bus.rsp_data, m_rspd);
            check("rsp_type", 32'(bus.rsp_type), 32'(m_rspt));
         end
         check("err_illegal", 32'(err_illegal), 32'(m_err));
         if (bus.req_do) begin
            issue_log.push_back(bus.req_addr);
            check("req_do_spacing", 32'((cyc - last_do) >= 3), 32'h1);
            last_do = cyc;
            do_cnt++;
         end
         if (bus.rsp_valid) rsp_cnt++;
         cyc++;
      end
   end

   // Cache responder: completes each issue after 1..lat_max cycles.
   bit          resp_en    = 1'b1;
   bit          spur_en    = 1'b0;
   bit          use_fixed  = 1'b0;
   logic [31:0] fixed_data = '0;
   int          lat_max    = 4;
   int          man_req    = 0;
   int          man_ack    = 0;
   int          lat        = 0;
   bit          pend       = 1'b0;

   initial begin
      bus.req_done   = 1'b0;
      bus.cache_data = '0;
      forever begin
         @(negedge clk);
         bus.req_done   = 1'b0;
         bus.cache_data = use_fixed ? fixed_data : $urandom;
         if (!reset) begin
            pend = 1'b0;
         end else if (man_req != man_ack) begin
            bus.req_done = 1'b1;
            man_ack = man_req;
            pend = 1'b0;
         end else if (pend && resp_en) begin
            lat--;
            if (lat <= 0) begin
               bus.req_done = 1'b1;
               pend = 1'b0;
            end
         end else if (!pend && spur_en && ($urandom_range(0, 7) == 0)) begin
            bus.req_done = 1'b1;
         end
         if (bus.req_do && reset) begin
            pend = 1'b1;
            lat  = $urandom_range(1, lat_max);
         end
      end
   end

   task automatic idle_inputs();
      bus.in_valid = 1'b0;
      bus.in_addr  = '0;
      bus.in_data  = '0;
      bus.in_type  = '0;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t,
                       output int waited, output bit rv);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_addr  = a;
      bus.in_data  = d;
      bus.in_type  = t;
      waited = 0;
      while (!bus.in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      rv = bus.rsp_valid;
      check("push_accepted", 32'(bus.in_ready), 32'h1);
      @(posedge clk);
      #2;
      idle_inputs();
   endtask

   task automatic wait_empty();
      int n;
      n = 0;
      while (count != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check("drain_empty", 32'(count), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int          w;
      bit          rv;
      int          base_do;
      int          base_rsp;
      int          base_log;
      int          legal;
      int          r;
      logic [31:0] exp_addr[$];
      logic [31:0] a;

      reset = 1'b0;
      idle_inputs();
      repeat (3) @(negedge clk);
      check("rst_count", 32'(count), 32'h0);
      check("rst_in_ready", 32'(bus.in_ready), 32'h1);
      check("rst_req_do", 32'(bus.req_do), 32'h0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      check("rst_err", 32'(err_illegal), 32'h0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Single read returning 0xDEADBEEF
      use_fixed = 1'b1; fixed_data = 32'hDEAD_BEEF; lat_max = 3;
      base_do = do_cnt; base_log = issue_log.size();
      push(32'h0000_0104, 32'h1111_2222, 2'b00, w, rv);
      w = 0;
      while (!bus.rsp_valid && w < 30) begin
         @(negedge clk);
         w++;
      end
      check("single_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      check("single_rsp_data", bus.rsp_data, 32'hDEAD_BEEF);
      check("single_rsp_type", 32'(bus.rsp_type), 32'h0);
      repeat (5) @(negedge clk);
      check("single_do_count", 32'(do_cnt - base_do), 32'h1);
      check("single_req_addr", issue_log[base_log], 32'h0000_0104);

      // Fill to full with the cache stalled
      resp_en = 1'b0; lat_max = 2;
      for (int i = 0; i < 4; i++)
         push(32'h200 + 32'(i * 4), 32'hA0 + 32'(i), 2'(i % 2), w, rv);
      repeat (2) @(negedge clk);
      check("full_count", 32'(count), 32'h4);
      check("full_in_ready", 32'(bus.in_ready), 32'h0);
      base_rsp = rsp_cnt;
      resp_en = 1'b1;
      push(32'h210, 32'hA4, 2'b00, w, rv);
      check("fifth_waited", 32'(w > 0), 32'h1);
      check("fifth_after_rsp", 32'(rv), 32'h1);
      check("fifth_rsp_count", 32'(rsp_cnt - base_rsp), 32'h1);
      wait_empty();
      check("full_rsp_total", 32'(rsp_cnt - base_rsp), 32'h5);

      // Illegal type is swallowed and flagged
      base_do = do_cnt;
      push(32'h300, 32'h0, 2'b11, w, rv);
      check("illegal_err_next", 32'(err_illegal), 32'h1);
      check("illegal_count", 32'(count), 32'h0);
      repeat (6) @(negedge clk);
      check("illegal_err_sticky", 32'(err_illegal), 32'h1);
      check("illegal_no_do", 32'(do_cnt - base_do), 32'h0);

      // Push coinciding with completion at count 2
      resp_en = 1'b0; use_fixed = 1'b0;
      base_log = issue_log.size();
      push(32'h400, 32'h40, 2'b00, w, rv);
      push(32'h404, 32'h44, 2'b01, w, rv);
      repeat (3) @(negedge clk);
      check("simul_pre_count", 32'(count), 32'h2);
      #1 man_req++;
      push(32'h408, 32'h48, 2'b00, w, rv);
      check("simul_count", 32'(count), 32'h2);
      check("simul_rsp", 32'(bus.rsp_valid), 32'h1);
      resp_en = 1'b1;
      wait_empty();
      check("simul_order0", issue_log[base_log], 32'h400);
      check("simul_order1", issue_log[base_log + 1], 32'h404);
      check("simul_order2", issue_log[base_log + 2], 32'h408);

      // Reset while an entry is in flight and two more are queued
      resp_en = 1'b0;
      for (int i = 0; i < 3; i++)
         push(32'h500 + 32'(i * 4), 32'h50 + 32'(i), 2'b00, w, rv);
      repeat (3) @(negedge clk);
      check("rstwait_pre_count", 32'(count), 32'h3);
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("rstwait_count", 32'(count), 32'h0);
      check("rstwait_in_ready", 32'(bus.in_ready), 32'h1);
      check("rstwait_req_do", 32'(bus.req_do), 32'h0);
      check("rstwait_req_addr", bus.req_addr, 32'h0);
      check("rstwait_req_data", bus.req_data, 32'h0);
      check("rstwait_req_type", 32'(bus.req_type), 32'h0);
      check("rstwait_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      check("rstwait_rsp_data", bus.rsp_data, 32'h0);
      check("rstwait_rsp_type", 32'(bus.rsp_type), 32'h0);
      check("rstwait_err", 32'(err_illegal), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      resp_en = 1'b1;
      base_rsp = rsp_cnt;
      repeat (10) @(negedge clk);
      check("rstwait_no_rsp", 32'(rsp_cnt - base_rsp), 32'h0);
      check("rstwait_count_after", 32'(count), 32'h0);

      // Ten ordered mixed requests, random latency and stray req_done pulses
      lat_max = 8; spur_en = 1'b1;
      base_log = issue_log.size(); base_rsp = rsp_cnt;
      for (int i = 0; i < 10; i++) begin
         a = $urandom;
         exp_addr.push_back(a);
         push(a, $urandom, 2'($urandom_range(0, 1)), w, rv);
      end
      wait_empty();
      for (int i = 0; i < 10; i++)
         check("order_addr", issue_log[base_log + i], exp_addr[i]);
      check("order_rsp_total", 32'(rsp_cnt - base_rsp), 32'd10);

      // Random traffic including flushes and illegal offers
      base_rsp = rsp_cnt; legal = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         bus.in_valid = ($urandom_range(0, 1) == 1);
         bus.in_addr  = $urandom;
         bus.in_data  = $urandom;
         r = $urandom_range(0, 15);
         bus.in_type  = (r == 0) ? 2'b11 : (r < 4) ? 2'b10 : (r < 10) ? 2'b00 : 2'b01;
         if (bus.in_valid && bus.in_ready && bus.in_type != 2'b11) legal++;
      end
      @(negedge clk);
      idle_inputs();
      wait_empty();
      check("random_rsp_total", 32'(rsp_cnt - base_rsp), 32'(legal));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cache_req_queue.md
CACHE_REQ_QUEUE -- requirements
Module: cache_req_queue

Interface
REQ-001 Parameter: DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-004 Port: in_valid  input  1  core request present.
REQ-005 Port: in_ready  output  1  queue can accept a request this cycle.
REQ-006 Port: in_addr  input  32  request address.
REQ-007 Port: in_data  input  32  write data.
REQ-008 Port: in_type  input  2  00 read, 01 write, 10 flush, 11 illegal.
REQ-009 Port: req_addr  output  32  address to cache.
REQ-010 Port: req_data  output  32  write data to cache.
REQ-011 Port: req_type  output  2  request type to cache.
REQ-012 Port: req_do  output  1  one-cycle issue strobe to cache.
REQ-013 Port: req_done  input  1  cache completion strobe, one cycle.
REQ-014 Port: cache_data  input  32  cache read data, valid while req_done is high.
REQ-015 Port: rsp_valid  output  1  one-cycle completion pulse to core.
REQ-016 Port: rsp_data  output  32  completed read data.
REQ-017 Port: rsp_type  output  2  type of the completed request.
REQ-018 Port: count  output  clog2(DEPTH)+1  number of queued entries, including the one in flight.
REQ-019 Port: err_illegal  output  1  sticky flag: an in_type of 11 was offered.

Function
REQ-020 The queue SHALL be a circular FIFO of {addr, data, type} with wrapping head/tail pointers and an explicit count.
REQ-021 in_ready SHALL equal (count < DEPTH), purely from registered count; a pop in the same cycle SHALL NOT raise in_ready.
REQ-022 A handshake (in_valid && in_ready) with in_type 00/01/10 SHALL write the entry at tail and advance tail and count on that edge.
REQ-023 A handshake with in_type 11 SHALL be consumed without enqueuing, SHALL set err_illegal, and SHALL produce no rsp_valid.
REQ-024 Issue FSM states: IDLE, ISSUE, WAIT.
REQ-025 IDLE: if count != 0, go to ISSUE; otherwise stay.
REQ-026 ISSUE: req_do SHALL be 1 for exactly this cycle; go to WAIT unconditionally.
REQ-027 WAIT: hold until req_done = 1; on that edge, capture cache_data into rsp_data and the head type into rsp_type, pulse rsp_valid for the following cycle, pop the head, and return to IDLE.
REQ-028 req_addr, req_data and req_type SHALL present the head entry and remain stable throughout ISSUE and WAIT; in IDLE, they SHALL be 0.
REQ-029 req_do SHALL be 0 in IDLE and WAIT; at most one request SHALL be outstanding at a time.
REQ-030 The minimum spacing between successive req_do strobes SHALL be 3 cycles, so each issue lands on the cache idle state.
REQ-031 rsp_data SHALL be cache_data for reads and 0 for writes and flushes.
REQ-032 Simultaneous push and pop SHALL leave count unchanged and SHALL update both pointers.
REQ-033 req_done asserted outside WAIT SHALL be ignored.
REQ-034 Entries SHALL complete strictly in enqueue order.

Reset
REQ-035 While reset = 0, outputs SHALL be: count 0, in_ready 1, req_do 0, req_addr/req_data/req_type 0, rsp_valid 0, rsp_data 0, rsp_type 0, err_illegal 0; FSM in IDLE; pointers 0.
REQ-036 Reset asserted during WAIT SHALL discard all entries, including the in-flight one, with no rsp_valid.

Verification
REQ-037 Single read: push {0x0000_0104, type 00} into an empty queue; cache returns req_done with cache_data 0xDEAD_BEEF -> exactly one req_do with req_addr 0x104; the next cycle gives rsp_valid = 1, rsp_data 0xDEAD_BEEF, rsp_type 00.
REQ-038 Fill to full: with DEPTH 4 and req_done held low, push 5 requests -> count reaches 4, in_ready drops to 0, and the 5th request is not accepted until after the first rsp_valid.
REQ-039 Ordering and wrap: push 10 mixed reads and writes with a random cache latency of 1-8 cycles -> 10 rsp_valid pulses in push order; pointers wrap without loss.
REQ-040 Illegal type: push in_type 11 -> err_illegal = 1 from the next cycle until reset, count unchanged, and no req_do.
REQ-041 Simultaneous push and pop: push on the cycle req_done is high with count 2 -> count stays 2 and the new entry is issued third.
REQ-042 Reset in WAIT: assert reset while 3 entries are queued -> all REQ-035 values take effect immediately; after release, no rsp_valid occurs and count stays 0.
